// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler.
// Contents: phase encoding, cfg_addr codes for the duration registers,
// default durations in ticks and the default pedestrian green remainder.
package traffic_pkg;

  // Fixed cycle order: S0 (G1,R2) -> S1 (Y1,R2) -> S2 (R1,G2) -> S3 (R1,Y2)
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } phase_t;

  // cfg_addr codes
  localparam logic [1:0] ADDR_G1 = 2'd0;
  localparam logic [1:0] ADDR_Y1 = 2'd1;
  localparam logic [1:0] ADDR_G2 = 2'd2;
  localparam logic [1:0] ADDR_Y2 = 2'd3;

  // Reset durations in ticks
  localparam int DEF_G1        = 15;
  localparam int DEF_Y1        = 5;
  localparam int DEF_G2        = 15;
  localparam int DEF_Y2        = 5;
  localparam int DEF_MIN_GREEN = 3;

endpackage

// File: rtl/phase_timer.sv
// Loadable, tick-enabled down counter holding the remaining ticks of the
// current phase.
// Ports:
//   clk, rs          clock, synchronous active-high reset (count <= RST_VAL)
//   tick             one-cycle pulse; decrements count while count > 1
//   load, load_val   reload at phase entry (highest priority after reset)
//   cut, cut_val     pedestrian shortening: force count to cut_val
//   count            current remaining ticks
//   expire           tick seen with count == 1: the phase ends this cycle
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cut,
  input  logic [CNT_W-1:0] cut_val,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  assign expire = tick && (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rs)
      count <= RST_VAL;
    else if (load)
      count <= load_val;
    else if (cut)
      count <= cut_val;
    else if (tick && (count > CNT_W'(1)))
      count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-direction traffic light phase scheduler.
// Cycles S0 (G1,R2) -> S1 (Y1,R2) -> S2 (R1,G2) -> S3 (R1,Y2), each phase
// lasting its programmed duration in ticks. Durations are written to shadow
// registers and only take effect when the corresponding phase is entered.
// Pedestrian requests shorten the running green to MIN_GREEN.
// Ports:
//   clk, rs                   clock, synchronous active-high reset
//   tick                      one-cycle pulse per second
//   cfg_we/cfg_addr/cfg_data  duration write (0=G1, 1=Y1, 2=G2, 3=Y2)
//   ped1_req, ped2_req        pedestrian requests for direction 1 / 2
//   X1,V1,D1 / X2,V2,D2       green/yellow/red lamps of direction 1 / 2
//   cnt1, cnt2                seconds until the lamp of direction 1 / 2 changes
//   phase                     current phase code
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int G1_DEF    = DEF_G1,
  parameter int Y1_DEF    = DEF_Y1,
  parameter int G2_DEF    = DEF_G2,
  parameter int Y2_DEF    = DEF_Y2,
  parameter int MIN_GREEN = DEF_MIN_GREEN
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             ped1_req,
  input  logic             ped2_req,
  output logic             X1,
  output logic             V1,
  output logic             D1,
  output logic             X2,
  output logic             V2,
  output logic             D2,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [1:0]       phase
);

  localparam logic [CNT_W-1:0] G1_RST = CNT_W'(G1_DEF);
  localparam logic [CNT_W-1:0] Y1_RST = CNT_W'(Y1_DEF);
  localparam logic [CNT_W-1:0] G2_RST = CNT_W'(G2_DEF);
  localparam logic [CNT_W-1:0] Y2_RST = CNT_W'(Y2_DEF);
  localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] G1_LD  = (G1_DEF == 0) ? CNT_W'(1) : G1_RST;
  localparam logic [CNT_W-1:0] Y1_LD  = (Y1_DEF == 0) ? CNT_W'(1) : Y1_RST;
  localparam logic [CNT_W-1:0] Y2_LD  = (Y2_DEF == 0) ? CNT_W'(1) : Y2_RST;

  // A zero duration still lasts one tick.
  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  phase_t           ph, ph_nxt, ph_d;
  logic [CNT_W-1:0] g1_sh, y1_sh, g2_sh, y2_sh;
  logic [CNT_W-1:0] y1_act, y2_act;
  logic [CNT_W-1:0] count, load_val;
  logic             adv, cut;
  logic             pend1, pend2;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (G1_LD)
  ) u_timer (
    .clk      (clk),
    .rs       (rs),
    .tick     (tick),
    .load     (adv),
    .load_val (load_val),
    .cut      (cut),
    .cut_val  (MIN_G),
    .count    (count),
    .expire   (adv)
  );

  // Phase FSM: state register
  always_ff @(posedge clk) begin
    if (rs) ph <= S0;
    else    ph <= ph_d;
  end

  // Phase FSM: successor phase and its entry duration. Shadows are read
  // before any same-cycle cfg write lands, so a coincident write only
  // affects later entries.
  always_comb begin
    ph_nxt   = S0;
    load_val = clamp1(g1_sh);
    unique case (ph)
      S0: begin ph_nxt = S1; load_val = clamp1(y1_sh); end
      S1: begin ph_nxt = S2; load_val = clamp1(g2_sh); end
      S2: begin ph_nxt = S3; load_val = clamp1(y2_sh); end
      S3: begin ph_nxt = S0; load_val = clamp1(g1_sh); end
    endcase
    ph_d = adv ? ph_nxt : ph;
  end

  // A request is honoured in the cycle it arrives as well as while pending,
  // so the count drops to MIN_GREEN on the edge after the request.
  assign cut = !adv && (count > MIN_G) &&
               (((ph == S0) && (pend1 || ped1_req)) ||
                ((ph == S2) && (pend2 || ped2_req)));

  always_ff @(posedge clk) begin
    if (rs) begin
      g1_sh  <= G1_RST;
      y1_sh  <= Y1_RST;
      g2_sh  <= G2_RST;
      y2_sh  <= Y2_RST;
      y1_act <= Y1_LD;
      y2_act <= Y2_LD;
      pend1  <= 1'b0;
      pend2  <= 1'b0;
    end else begin
      if (cfg_we) begin
        unique case (cfg_addr)
          ADDR_G1: g1_sh <= cfg_data;
          ADDR_Y1: y1_sh <= cfg_data;
          ADDR_G2: g2_sh <= cfg_data;
          ADDR_Y2: y2_sh <= cfg_data;
        endcase
      end
      // Yellow actives only change on entry to their own phase.
      if (adv && (ph_nxt == S1)) y1_act <= clamp1(y1_sh);
      if (adv && (ph_nxt == S3)) y2_act <= clamp1(y2_sh);
      // Pending only lives during the matching green; leaving green drops it
      // together with any request arriving in that last cycle.
      pend1 <= (ph == S0) && !adv && (pend1 || ped1_req);
      pend2 <= (ph == S2) && !adv && (pend2 || ped2_req);
    end
  end

  // Display: the red side sees its wait through the other side's yellow.
  logic [CNT_W:0] sum1, sum2;
  assign sum1 = {1'b0, count} + {1'b0, y2_act};
  assign sum2 = {1'b0, count} + {1'b0, y1_act};

  always_comb begin
    cnt1 = count;
    cnt2 = count;
    if (ph == S2) cnt1 = sum1[CNT_W] ? '1 : sum1[CNT_W-1:0];
    if (ph == S0) cnt2 = sum2[CNT_W] ? '1 : sum2[CNT_W-1:0];
  end

  // Lamps decoded straight from the phase register.
  assign X1    = (ph == S0);
  assign V1    = (ph == S1);
  assign D1    = (ph == S2) || (ph == S3);
  assign X2    = (ph == S2);
  assign V2    = (ph == S3);
  assign D2    = (ph == S0) || (ph == S1);
  assign phase = ph;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler.
module tb_traffic_phase_scheduler;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rs = 1'b1, tick = 1'b0, cfg_we = 1'b0;
  logic [1:0]       cfg_addr = 2'd0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic             ped1_req = 1'b0, ped2_req = 1'b0;
  logic             X1, V1, D1, X2, V2, D2;
  logic [CNT_W-1:0] cnt1, cnt2;
  logic [1:0]       phase;

  int checks = 0;
  int failures = 0;

  traffic_phase_scheduler #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rs(rs), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ped1_req(ped1_req), .ped2_req(ped2_req),
    .X1(X1), .V1(V1), .D1(D1), .X2(X2), .V2(V2), .D2(D2),
    .cnt1(cnt1), .cnt2(cnt2), .phase(phase)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  task automatic cfg_write(input logic [1:0] a, input int d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = CNT_W'(d);
    step();
    cfg_we = 1'b0;
  endtask

  // Checks we are in phase ph, then counts ticks until the phase changes.
  task automatic measure(input string tag, input logic [1:0] ph, input int len);
    int n;
    n = 0;
    chk({tag, "_phase"}, phase, ph);
    while (phase == ph && n < 400) begin
      pulse_tick();
      n++;
    end
    chk({tag, "_len"}, n, len);
  endtask

  function automatic logic [5:0] lamps();
    return {X1, V1, D1, X2, V2, D2};
  endfunction

  initial begin
    // Reset state
    rs = 1'b1;
    step();
    chk("rst_phase", phase, 0);
    chk("rst_cnt1", cnt1, 15);
    chk("rst_cnt2", cnt2, 20);
    chk("rst_lamps", lamps(), 6'b100001);
    rs = 1'b0;

    // Hold without tick
    step(); step(); step();
    chk("hold_cnt1", cnt1, 15);
    chk("hold_phase", phase, 0);

    // Default cycle
    pulse_tick();
    chk("dec_cnt1", cnt1, 14);
    chk("dec_cnt2", cnt2, 19);
    measure("def_s0", 2'd0, 14);
    chk("s1_lamps", lamps(), 6'b010001);
    chk("s1_cnt1", cnt1, 5);
    chk("s1_cnt2", cnt2, 5);
    measure("def_s1", 2'd1, 5);
    chk("s2_lamps", lamps(), 6'b001100);
    chk("s2_cnt1", cnt1, 20);
    chk("s2_cnt2", cnt2, 15);
    measure("def_s2", 2'd2, 15);
    chk("s3_lamps", lamps(), 6'b001010);
    measure("def_s3", 2'd3, 5);
    chk("wrap_phase", phase, 0);
    chk("wrap_cnt1", cnt1, 15);

    // Shadow writes during S0
    cfg_write(2'd2, 7);
    cfg_write(2'd0, 2);
    chk("wr_nochange", cnt1, 15);
    measure("wr_s0", 2'd0, 15);
    measure("wr_s1", 2'd1, 5);
    measure("wr_s2", 2'd2, 7);
    measure("wr_s3", 2'd3, 5);
    measure("wr_s0b", 2'd0, 2);
    cfg_write(2'd0, 15);
    cfg_write(2'd2, 15);
    measure("rest_s1", 2'd1, 5);
    measure("rest_s2", 2'd2, 15);
    measure("rest_s3", 2'd3, 5);

    // Pedestrian request in S0
    ticks(3);
    chk("ped_pre", cnt1, 12);
    ped1_req = 1'b1;
    step();
    ped1_req = 1'b0;
    chk("ped1_cut", cnt1, 3);
    chk("ped1_cnt2", cnt2, 8);
    measure("ped_s0", 2'd0, 3);
    measure("ped_s1", 2'd1, 5);
    // ped1 during S2 has no effect; ped2 cuts S2
    ticks(2);
    ped1_req = 1'b1;
    step();
    ped1_req = 1'b0;
    step();
    chk("ped1_s2_none", cnt2, 13);
    ped2_req = 1'b1;
    step();
    ped2_req = 1'b0;
    chk("ped2_cut", cnt2, 3);
    measure("ped_s2", 2'd2, 3);
    measure("ped_s3", 2'd3, 5);

    // Y1 = 0 lasts one tick
    cfg_write(2'd1, 0);
    measure("y0_s0", 2'd0, 15);
    measure("y0_s1", 2'd1, 1);
    cfg_write(2'd1, 5);
    measure("y0_s2", 2'd2, 15);
    measure("y0_s3", 2'd3, 5);
    chk("y0_act_cnt2", cnt2, 16);

    // Y1 write coinciding with the S0->S1 reload (Y1 currently 5)
    ticks(14);
    chk("co_cnt1", cnt1, 1);
    tick = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd9;
    step();
    tick = 1'b0; cfg_we = 1'b0;
    chk("co_phase", phase, 1);
    chk("co_old_y1", cnt1, 5);
    measure("co_s1", 2'd1, 5);
    measure("co_s2", 2'd2, 15);
    measure("co_s3", 2'd3, 5);
    measure("co_s0", 2'd0, 15);
    measure("co_s1new", 2'd1, 9);

    // Saturating display: G2=200, Y2=250
    cfg_write(2'd3, 250);
    cfg_write(2'd2, 200);
    measure("sat_s2", 2'd2, 15);
    measure("sat_s3", 2'd3, 250);
    measure("sat_s0", 2'd0, 15);
    measure("sat_s1", 2'd1, 9);
    chk("sat_cnt1", cnt1, 255);
    chk("sat_cnt2", cnt2, 200);

    // Reset mid-S2 with count 9, beating tick and cfg_we
    ticks(191);
    chk("mid_cnt2", cnt2, 9);
    rs = 1'b1; tick = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd4;
    step();
    rs = 1'b0; tick = 1'b0; cfg_we = 1'b0;
    chk("mrst_phase", phase, 0);
    chk("mrst_cnt1", cnt1, 15);
    chk("mrst_lamps", lamps(), 6'b100001);
    chk("mrst_cnt2", cnt2, 20);
    measure("mrst_s0", 2'd0, 15);
    measure("mrst_s1", 2'd1, 5);
    measure("mrst_s2", 2'd2, 15);
    measure("mrst_s3", 2'd3, 5);
    measure("mrst_s0b", 2'd0, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
